// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
// The next-state table is built here at elaboration time using KMP failure links.
package seq_det_pkg;

  localparam int unsigned PAT_WIDTH_MIN = 2;
  localparam int unsigned PAT_WIDTH_MAX = 16;
  localparam int unsigned CNT_WIDTH_MIN = 1;
  localparam int unsigned CNT_WIDTH_MAX = 16;
  localparam int unsigned ST_W          = 5;

  typedef logic [ST_W-1:0] st_t;
  typedef st_t [PAT_WIDTH_MAX:0][1:0] next_tbl_t;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input logic [15:0] pat, input int unsigned w,
                                   input int unsigned i);
    return pat[w-1-i];
  endfunction

  // Longest proper prefix of the first len pattern bits that is also their suffix.
  function automatic int unsigned failure_link(input logic [15:0] pat, input int unsigned w,
                                               input int unsigned len);
    int unsigned best;
    bit          ok;
    best = 0;
    for (int unsigned k = 1; k < PAT_WIDTH_MAX; k++) begin
      if (k < len) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < PAT_WIDTH_MAX; j++) begin
          if (j < k && pat_bit(pat, w, j) != pat_bit(pat, w, len - k + j)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic int unsigned kmp_step(input logic [15:0] pat, input int unsigned w,
                                           input int unsigned start, input logic b);
    int unsigned k;
    int unsigned res;
    bit          done;
    k    = start;
    res  = 0;
    done = 1'b0;
    for (int unsigned n = 0; n <= PAT_WIDTH_MAX; n++) begin
      if (!done) begin
        if (k < w && b == pat_bit(pat, w, k)) begin
          res  = k + 1;
          done = 1'b1;
        end else if (k == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          k = failure_link(pat, w, k);
        end
      end
    end
    return res;
  endfunction

  // Rows above PAT_WIDTH are unreachable and left at zero.
  function automatic next_tbl_t build_next_tbl(input logic [15:0] pat, input int unsigned w,
                                               input bit ovl);
    next_tbl_t   tbl;
    int unsigned k;
    tbl = '0;
    for (int unsigned s = 0; s <= PAT_WIDTH_MAX; s++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (s <= w) begin
          if (s == w) k = ovl ? failure_link(pat, w, w) : 0;
          else        k = s;
          tbl[s][b] = st_t'(kmp_step(pat, w, k, b[0]));
        end
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating match counter with synchronous clear and a registered saturation flag.
module seq_det_sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 sat
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && count_q != CNT_MAX) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
    sat_d = (count_d == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/param_seq_detector.sv
// Moore serial-pattern detector: state is the matched-prefix length, PAT_WIDTH means MATCH.
// The transition table is a constant, so match has no combinational path from the inputs.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1101,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int unsigned          CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 serial_in,
  output logic                 match,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 count_sat
);

  localparam int unsigned     SW       = $clog2(PAT_WIDTH + 1);
  localparam logic [SW-1:0]   MATCH_ST = SW'(PAT_WIDTH);
  localparam next_tbl_t       NEXT_TBL = build_next_tbl(16'(PATTERN), PAT_WIDTH, OVERLAP);

  logic [SW-1:0] state_q, state_d;
  logic          match_q;
  logic          inc;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = '0;
    end else if (enable) begin
      state_d = SW'(NEXT_TBL[ST_W'(state_q)][serial_in]);
    end
  end

  // Every enabled entry into MATCH counts, including MATCH->MATCH.
  assign inc = enable && !clear && (state_d == MATCH_ST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= (state_d == MATCH_ST);
    end
  end

  seq_det_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .clear(clear),
    .count(match_count),
    .sat  (count_sat)
  );

  assign match = match_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: three configurations share one stimulus stream and are
// checked against a history-based reference model through a scoreboard queue.
module tb_param_seq_detector;

  logic       clk, rst, clear, enable, serial_in;
  logic       m0, m1, m2;
  logic       s0, s1, s2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  param_seq_detector u0 (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .serial_in(serial_in),
    .match(m0), .match_count(c0), .count_sat(s0)
  );

  param_seq_detector #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .serial_in(serial_in),
    .match(m1), .match_count(c1), .count_sat(s1)
  );

  param_seq_detector #(.PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .serial_in(serial_in),
    .match(m2), .match_count(c2), .count_sat(s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] m;
    logic [2:0] s;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] PATS [3] = '{4'b1101, 4'b1101, 4'b1111};
  localparam bit         OVL  [3] = '{1'b1, 1'b0, 1'b1};
  localparam int         CMAX [3] = '{255, 255, 3};

  logic [15:0] hist [3];
  int          nv   [3];
  int          cnt  [3];
  logic        mm   [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i] = '0;
      nv[i]   = 0;
      cnt[i]  = 0;
      mm[i]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic b, input logic en, input logic clr);
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        nv[i]  = 0;
        cnt[i] = 0;
        mm[i]  = 1'b0;
      end else if (en) begin
        if (mm[i] && !OVL[i]) nv[i] = 0;
        hist[i] = {hist[i][14:0], b};
        if (nv[i] < 16) nv[i]++;
        mm[i] = (nv[i] >= 4) && (hist[i][3:0] == PATS[i]);
        if (mm[i] && cnt[i] < CMAX[i]) cnt[i]++;
      end
    end
  endtask

  task automatic drive(input logic b, input logic en, input logic clr);
    exp_t e;
    serial_in = b;
    enable    = en;
    clear     = clr;
    model_step(b, en, clr);
    e.m  = {mm[2], mm[1], mm[0]};
    e.s  = {cnt[2] == 3, cnt[1] == 255, cnt[0] == 255};
    e.c0 = 8'(cnt[0]);
    e.c1 = 8'(cnt[1]);
    e.c2 = 2'(cnt[2]);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; enable = 1'b0; serial_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m2, m1, m0, s2, s1, s0, c0, c1, c2} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {m2, m1, m0, s2, s1, s0, c0, c1, c2});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream_modes();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] want0 = 7'b0001001;
    logic [6:0] want1 = 7'b0001000;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      drive(bits[6-i], 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({m2, m1, m0} !== e.m) begin
        errors++; $display("FAIL stream_match bit%0d got=%b want=%b", i + 1, {m2, m1, m0}, e.m);
      end
      checks++;
      if ({c0, c1, c2} !== {e.c0, e.c1, e.c2}) begin
        errors++; $display("FAIL stream_count bit%0d got=%h want=%h", i + 1, {c0, c1, c2}, {e.c0, e.c1, e.c2});
      end
      checks++;
      if ({m1, m0} !== {want1[6-i], want0[6-i]}) begin
        errors++; $display("FAIL stream_match_ref bit%0d got=%b want=%b", i + 1, {m1, m0}, {want1[6-i], want0[6-i]});
      end
    end
    checks++;
    if (c0 !== 8'd2) begin errors++; $display("FAIL overlap_count got=%0d want=2", c0); end
    checks++;
    if (c1 !== 8'd1) begin errors++; $display("FAIL no_overlap_count got=%0d want=1", c1); end
  endtask

  task automatic test_pause();
    logic [6:0] bits = 7'b1101011;
    logic [6:0] ens  = 7'b1110001;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      drive(bits[6-i], ens[6-i], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({m2, m1, m0} !== e.m || {c0, c1, c2} !== {e.c0, e.c1, e.c2}) begin
        errors++; $display("FAIL pause_step%0d got=%b/%h want=%b/%h", i, {m2, m1, m0}, {c0, c1, c2}, e.m, {e.c0, e.c1, e.c2});
      end
      checks++;
      if (m0 !== (i == 6)) begin
        errors++; $display("FAIL pause_match_ref step%0d got=%b want=%b", i, m0, (i == 6));
      end
    end
    checks++;
    if (c0 !== 8'd3) begin errors++; $display("FAIL pause_count got=%0d want=3", c0); end
  endtask

  task automatic test_async_reset();
    logic [3:0] post = 4'b1101;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive((i < 2), 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({m2, m1, m0} !== e.m) begin
        errors++; $display("FAIL arst_pre step%0d got=%b want=%b", i, {m2, m1, m0}, e.m);
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({m0, c0, s0, m2, c2, s2} !== 13'h0) begin
      errors++; $display("FAIL arst_immediate got=%h want=0", {m0, c0, s0, m2, c2, s2});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({m0, c0, m1, c1} !== 18'h0) begin
      errors++; $display("FAIL arst_held got=%h want=0", {m0, c0, m1, c1});
    end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(post[3-i], 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({m2, m1, m0} !== e.m || {c0, c1, c2} !== {e.c0, e.c1, e.c2}) begin
        errors++; $display("FAIL arst_post step%0d got=%b/%h want=%b/%h", i, {m2, m1, m0}, {c0, c1, c2}, e.m, {e.c0, e.c1, e.c2});
      end
      checks++;
      if (m0 !== (i == 3)) begin
        errors++; $display("FAIL arst_post_ref step%0d got=%b want=%b", i, m0, (i == 3));
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] want_m = 8'b00011111;
    logic [1:0] want_c [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_t e;
    drive(1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({c0, c2, s2} !== {e.c0, e.c2, e.s[2]}) begin
      errors++; $display("FAIL sat_preclear got=%h want=%h", {c0, c2, s2}, {e.c0, e.c2, e.s[2]});
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({m2, m1, m0} !== e.m || {s2, s1, s0} !== e.s || {c0, c1, c2} !== {e.c0, e.c1, e.c2}) begin
        errors++; $display("FAIL sat_step bit%0d got=%b/%b/%h want=%b/%b/%h", i + 1, {m2, m1, m0}, {s2, s1, s0}, {c0, c1, c2}, e.m, e.s, {e.c0, e.c1, e.c2});
      end
      checks++;
      if ({m2, c2, s2} !== {want_m[7-i], want_c[i], (i >= 5)}) begin
        errors++; $display("FAIL sat_ref bit%0d got=%b want=%b", i + 1, {m2, c2, s2}, {want_m[7-i], want_c[i], (i >= 5)});
      end
    end
    drive(1'b1, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({m2, c2, s2} !== 4'b0000 || {m2, c2, s2} !== {e.m[2], e.c2, e.s[2]}) begin
      errors++; $display("FAIL sat_clear got=%b want=0000", {m2, c2, s2});
    end
  endtask

  task automatic test_clear_collision();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      // Third bit completes "110"; the fourth edge carries the final 1 together with clear.
      drive((i != 2), 1'b1, (i == 3));
      e = sb.pop_front();
      checks++;
      if ({m2, m1, m0} !== e.m || {c0, c1, c2} !== {e.c0, e.c1, e.c2}) begin
        errors++; $display("FAIL collide_step%0d got=%b/%h want=%b/%h", i, {m2, m1, m0}, {c0, c1, c2}, e.m, {e.c0, e.c1, e.c2});
      end
    end
    checks++;
    if ({m0, c0} !== 9'h0) begin
      errors++; $display("FAIL collide_ref got=%b/%0d want=0/0", m0, c0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream_modes();
    test_pause();
    test_async_reset();
    test_saturate();
    test_clear_collision();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
